// File: rtl/cdf_writeback.sv
// cdf_writeback: write-back end of the CDF pipeline.
// Buffers accumulated CDF bins in a small FIFO and writes them to
// CDF memory as tagged 128-bit words, then raises done after BINS writes.
// Ports:
//   clock, reset_n            clock (rising edge), async active-low reset
//   start                     frame enable (level); low aborts to idle
//   in_valid/in_data/in_addr  bin stream from the accumulate stage
//   output_base_offset        memory half select (WriteAddress MSB)
//   in_stall                  FIFO full, in_valid ignored while high
//   WriteBus/WriteAddress     write word and address
//   WriteEnable/write_ready   write request / memory accept handshake
//   done                      frame complete, held until start falls
module cdf_writeback #(
    parameter int          DATA_W     = 20,
    parameter int          ADDR_W     = 16,
    parameter int          BINS       = 256,
    parameter logic [15:0] TAG        = 16'hAAAA,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              output_base_offset,
    output logic              in_stall,
    output logic [127:0]      WriteBus,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic              WriteEnable,
    input  logic              write_ready,
    output logic              done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int NW = $clog2(BINS + 1);
    localparam logic [NW-1:0] BINS_N = NW'(BINS);
    localparam logic [NW-1:0] LAST_N = NW'(BINS - 1);
    localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_fdata [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_faddr [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_next;
    logic [NW-1:0]     r_acc_cnt;
    logic [NW-1:0]     r_wr_cnt;
    logic              r_stall;
    logic              r_we;
    logic [127:0]      r_bus;
    logic [ADDR_W-1:0] r_addr;

    logic              w_active;
    logic              w_push;
    logic              w_load;
    logic              w_hs;
    logic              w_pop;
    logic              w_last;
    logic [127:0]      w_word;
    logic [ADDR_W-1:0] w_push_addr;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    // Full blocks a push even if a pop happens on the same edge.
    assign w_push = start && (r_state == S_RUN) && in_valid &&
                    !r_stall && (r_acc_cnt < BINS_N);
    // Output slot is free when empty or its word is being accepted.
    assign w_load = !r_we || write_ready;
    assign w_hs   = r_we && write_ready;
    assign w_pop  = start && w_active && w_load && (r_count != '0);
    assign w_last = w_hs && (r_wr_cnt == LAST_N);

    assign w_push_addr = {output_base_offset, in_addr[ADDR_W-2:0]};

    always_comb begin
        w_word = '0;
        w_word[35:20] = TAG;
        w_word[DATA_W-1:0] = r_fdata[r_rd_ptr];
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        if (!start) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_next = S_RUN;
                S_RUN: begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else if (r_acc_cnt == BINS_N) begin
                        w_next = S_DRAIN;
                    end
                end
                // The final handshake empties the pipe; done rises with it.
                S_DRAIN: begin
                    if (w_last && (r_count == '0)) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fdata[r_wr_ptr] <= in_data;
            r_faddr[r_wr_ptr] <= w_push_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            r_stall   <= 1'b0;
            r_we      <= 1'b0;
            r_bus     <= '0;
            r_addr    <= '0;
        end else begin
            r_state <= w_next;
            if (!start) begin
                // Abort: discard buffered and pending words.
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_acc_cnt <= '0;
                r_wr_cnt  <= '0;
                r_stall   <= 1'b0;
                r_we      <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                    r_acc_cnt <= r_acc_cnt + NW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= w_count_next;
                r_stall <= (w_count_next == FULL_N);
                if (w_hs) begin
                    r_wr_cnt <= r_wr_cnt + NW'(1);
                end
                if (w_load) begin
                    r_we <= w_pop;
                    if (w_pop) begin
                        r_bus  <= w_word;
                        r_addr <= r_faddr[r_rd_ptr];
                    end
                end
            end
        end
    end

    assign in_stall     = r_stall;
    assign WriteBus     = r_bus;
    assign WriteAddress = r_addr;
    assign WriteEnable  = r_we;
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_cdf_writeback.sv
// tb_cdf_writeback: randomized self-checking bench for cdf_writeback.
// Expected write stream comes from a queue model of accepted bins.
module tb_cdf_writeback;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 16;
    localparam int BINS   = 256;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              output_base_offset;
    logic              in_stall;
    logic [127:0]      WriteBus;
    logic [ADDR_W-1:0] WriteAddress;
    logic              WriteEnable;
    logic              write_ready;
    logic              done;

    cdf_writeback dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_addr            (in_addr),
        .output_base_offset (output_base_offset),
        .in_stall           (in_stall),
        .WriteBus           (WriteBus),
        .WriteAddress       (WriteAddress),
        .WriteEnable        (WriteEnable),
        .write_ready        (write_ready),
        .done               (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errs    = 0;

    logic [127:0]      exp_w [$];
    logic [ADDR_W-1:0] exp_a [$];
    logic [127:0]      obs_w [$];
    logic [ADDR_W-1:0] obs_a [$];
    bit run      = 0;
    bit rnd_mode = 0;
    int acc      = 0;
    int idx      = 0;

    // One clock: log handshakes seen, model accepted pushes.
    task automatic step();
        if (WriteEnable && write_ready) begin
            obs_w.push_back(WriteBus);
            obs_a.push_back(WriteAddress);
        end
        if (run && in_valid && !in_stall && acc < BINS) begin
            exp_w.push_back({92'h0, 16'hAAAA, in_data});
            exp_a.push_back({output_base_offset, in_addr[ADDR_W-2:0]});
            acc++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_step(bit v, int rdy_pct);
        bit fired;
        in_valid = v;
        if (rnd_mode) begin
            in_data = DATA_W'($urandom);
            in_addr = ADDR_W'($urandom);
            output_base_offset = 1'($urandom);
        end else begin
            in_data = DATA_W'(idx * 3);
            in_addr = ADDR_W'(idx);
        end
        write_ready = ($urandom_range(0, 99) < rdy_pct);
        fired = v && !in_stall;
        step();
        if (fired) idx++;
    endtask

    task automatic drive_to(int n, int rdy_pct, int v_pct);
        int guard = 0;
        while (idx < n && guard < 4000) begin
            pulse_step($urandom_range(0, 99) < v_pct, rdy_pct);
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic begin_frame();
        exp_w.delete();
        exp_a.delete();
        obs_w.delete();
        obs_a.delete();
        acc = 0;
        idx = 0;
        in_valid = 1'b0;
        start = 1'b1;
        step();
        run = 1;
    endtask

    task automatic wait_done(int rdy_pct, output bit ok);
        int guard = 0;
        in_valid = 1'b0;
        while (!done && guard < 3000) begin
            write_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
            guard++;
        end
        ok = done;
        write_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic end_frame();
        start = 1'b0;
        in_valid = 1'b0;
        run = 0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_addr = '0;
        output_base_offset = 1'b0;
        write_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (WriteEnable !== 1'b0 || WriteBus !== 128'h0 ||
            WriteAddress !== 16'h0 || in_stall !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL reset we=%b bus=%h addr=%h stall=%b done=%b want all 0",
                     WriteEnable, WriteBus, WriteAddress, in_stall, done);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_frame(bit off, string nm);
        bit ok;
        rnd_mode = 0;
        output_base_offset = off;
        begin_frame();
        drive_to(BINS, 100, 100);
        wait_done(100, ok);
        vectors++;
        if (!ok || done !== 1'b1 || WriteEnable !== 1'b0) begin
            errs++;
            $display("FAIL %s_done done=%b we=%b want done=1 we=0", nm, done, WriteEnable);
        end
        vectors++;
        if (obs_w.size() != BINS) begin
            errs++;
            $display("FAIL %s_count got %0d want %0d", nm, obs_w.size(), BINS);
        end
        for (int k = 0; k < obs_w.size() && k < BINS; k++) begin
            vectors++;
            if (obs_w[k] !== {92'h0, 16'hAAAA, 20'(k * 3)} ||
                obs_a[k] !== {off, 15'(k)}) begin
                errs++;
                $display("FAIL %s_word%0d got %h@%h want %h@%h", nm, k, obs_w[k],
                         obs_a[k], {92'h0, 16'hAAAA, 20'(k * 3)}, {off, 15'(k)});
            end
        end
        end_frame();
        vectors++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL %s_done_clear got %b want 0", nm, done);
        end
    endtask

    task automatic test_random();
        bit ok;
        rnd_mode = 1;
        begin_frame();
        drive_to(BINS, 60, 70);
        wait_done(60, ok);
        vectors++;
        if (!ok || obs_w.size() != exp_w.size()) begin
            errs++;
            $display("FAIL rnd_count done=%b got %0d want %0d", ok, obs_w.size(), exp_w.size());
        end
        for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++) begin
            vectors++;
            if (obs_w[k] !== exp_w[k] || obs_a[k] !== exp_a[k]) begin
                errs++;
                $display("FAIL rnd_word%0d got %h@%h want %h@%h", k, obs_w[k],
                         obs_a[k], exp_w[k], exp_a[k]);
            end
        end
        end_frame();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [127:0] held_w;
        logic [ADDR_W-1:0] held_a;
        rnd_mode = 0;
        output_base_offset = 1'b0;
        begin_frame();
        drive_to(20, 100, 100);
        pulse_step(1'b1, 0);
        held_w = WriteBus;
        held_a = WriteAddress;
        repeat (9) pulse_step(1'b1, 0);
        vectors++;
        if (in_stall !== 1'b1 || WriteEnable !== 1'b1) begin
            errs++;
            $display("FAIL bp_stall stall=%b we=%b want 1 1", in_stall, WriteEnable);
        end
        vectors++;
        if (WriteBus !== held_w || WriteAddress !== held_a) begin
            errs++;
            $display("FAIL bp_hold got %h@%h want %h@%h", WriteBus, WriteAddress,
                     held_w, held_a);
        end
        drive_to(BINS, 50, 100);
        wait_done(50, ok);
        vectors++;
        if (!ok || obs_w.size() != BINS) begin
            errs++;
            $display("FAIL bp_count done=%b got %0d want %0d", ok, obs_w.size(), BINS);
        end
        for (int k = 0; k < obs_w.size() && k < BINS; k++) begin
            vectors++;
            if (obs_w[k] !== {92'h0, 16'hAAAA, 20'(k * 3)} || obs_a[k] !== 16'(k)) begin
                errs++;
                $display("FAIL bp_word%0d got %h@%h want data %h addr %h", k,
                         obs_w[k], obs_a[k], 20'(k * 3), 16'(k));
            end
        end
        end_frame();
    endtask

    task automatic test_overrun();
        bit ok;
        rnd_mode = 0;
        output_base_offset = 1'b0;
        begin_frame();
        drive_to(BINS + 4, 80, 100);
        wait_done(80, ok);
        vectors++;
        if (!ok || obs_w.size() != BINS || exp_w.size() != BINS) begin
            errs++;
            $display("FAIL ovr_count done=%b got %0d want %0d", ok, obs_w.size(), BINS);
        end
        for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++) begin
            vectors++;
            if (obs_w[k] !== exp_w[k] || obs_a[k] !== exp_a[k]) begin
                errs++;
                $display("FAIL ovr_word%0d got %h@%h want %h@%h", k, obs_w[k],
                         obs_a[k], exp_w[k], exp_a[k]);
            end
        end
        end_frame();
    endtask

    task automatic test_abort();
        bit ok;
        int guard = 0;
        rnd_mode = 1;
        begin_frame();
        while (obs_w.size() < 100 && guard < 2000) begin
            pulse_step(1'b1, 100);
            guard++;
        end
        repeat (6) pulse_step(1'b1, 0);
        start = 1'b0;
        in_valid = 1'b0;
        run = 0;
        step();
        vectors++;
        if (WriteEnable !== 1'b0 || in_stall !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL abort we=%b stall=%b done=%b want 0 0 0",
                     WriteEnable, in_stall, done);
        end
        write_ready = 1'b1;
        step();
        vectors++;
        if (WriteEnable !== 1'b0) begin
            errs++;
            $display("FAIL abort_idle we=%b want 0", WriteEnable);
        end
        begin_frame();
        drive_to(BINS, 70, 80);
        wait_done(70, ok);
        vectors++;
        if (!ok || obs_w.size() != BINS || exp_w.size() != BINS) begin
            errs++;
            $display("FAIL restart_count done=%b got %0d want %0d", ok, obs_w.size(), BINS);
        end
        for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++) begin
            vectors++;
            if (obs_w[k] !== exp_w[k] || obs_a[k] !== exp_a[k]) begin
                errs++;
                $display("FAIL restart_word%0d got %h@%h want %h@%h", k, obs_w[k],
                         obs_a[k], exp_w[k], exp_a[k]);
            end
        end
        end_frame();
    endtask

    task automatic test_reset_drain();
        rnd_mode = 0;
        output_base_offset = 1'b1;
        begin_frame();
        drive_to(BINS, 100, 100);
        write_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if (WriteEnable !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL drain_hold we=%b done=%b want 1 0", WriteEnable, done);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (WriteEnable !== 1'b0 || WriteBus !== 128'h0 ||
            WriteAddress !== 16'h0 || in_stall !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL drain_reset we=%b bus=%h addr=%h stall=%b done=%b want all 0",
                     WriteEnable, WriteBus, WriteAddress, in_stall, done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        obs_w.delete();
        write_ready = 1'b1;
        repeat (8) step();
        vectors++;
        if (obs_w.size() != 0 || WriteEnable !== 1'b0) begin
            errs++;
            $display("FAIL post_reset writes=%0d we=%b want 0 0", obs_w.size(), WriteEnable);
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, "base0");
        test_frame(1'b1, "base1");
        test_random();
        test_backpressure();
        test_overrun();
        test_abort();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
